// File: rtl/qeciphy_gt_link_sequencer.sv
// qeciphy_gt_link_sequencer: GTH bring-up/recovery sequencer; define QECIPHY_GT_RETRY_LIMIT_EN to enable the retry limit and FAILED state
module qeciphy_gt_link_sequencer #(
  parameter int RESET_PULSE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES      = 1048576,
  parameter int ALIGN_STABLE_CYCLES = 256,
  parameter int MAX_RETRIES         = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       gtpowergood,
  input  logic       qpll0lock,
  input  logic       tx_done,
  input  logic       rx_done,
  input  logic       rx_cdr_stable,
  input  logic       rxbyteisaligned,
  input  logic       rxbyterealign,
  output logic       reset_all,
  output logic       reset_rx_datapath,
  output logic       comma_align_en,
  output logic       tx_ready,
  output logic       rx_ready,
  output logic [3:0] state,
  output logic [7:0] retry_count,
  output logic       failed
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SW = $clog2(ALIGN_STABLE_CYCLES + 1);
`ifdef QECIPHY_GT_RETRY_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif
  typedef enum logic [3:0] {
    IDLE = 4'd0, RST_ALL = 4'd1, WAIT_PLL = 4'd2, WAIT_TX = 4'd3, WAIT_RX = 4'd4,
    ALIGN = 4'd5, READY = 4'd6, RX_RST = 4'd7, RETRY = 4'd8, FAILED = 4'd9
  } state_t;
  state_t state_q, state_d, retry_tgt, rxrst_tgt;
  logic [6:0] meta_q, sync_q;
  logic realign_prev_q;
  logic [TW-1:0] cnt_q;
  logic [SW-1:0] stab_q, stab_d;
  logic [7:0] retry_q, retry_d;
  logic reset_all_q, reset_rx_q, comma_q, tx_ready_q, rx_ready_q, failed_q;
  logic pg_s, pll_s, tx_s, rx_s, cdr_s, aligned_s, realign_s, realign_ev;
  logic timeout, pulse_done, retry_lim;
  assign {realign_s, aligned_s, cdr_s, rx_s, tx_s, pll_s, pg_s} = sync_q;
  assign realign_ev = realign_s & ~realign_prev_q;
  assign timeout = cnt_q == TW'(TIMEOUT_CYCLES - 1);
  assign pulse_done = cnt_q == TW'(RESET_PULSE_CYCLES - 1);
  assign retry_lim = LIMIT_EN && (retry_q >= 8'(MAX_RETRIES));
  assign retry_tgt = retry_lim ? FAILED : RETRY;
  assign rxrst_tgt = retry_lim ? FAILED : RX_RST;
  assign state = state_q;
  assign retry_count = retry_q;
  assign reset_all = reset_all_q;
  assign reset_rx_datapath = reset_rx_q;
  assign comma_align_en = comma_q;
  assign tx_ready = tx_ready_q;
  assign rx_ready = rx_ready_q;
  assign failed = failed_q;
  // two-flop synchronisers plus the previous realign level for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
      realign_prev_q <= 1'b0;
    end else begin
      meta_q <= {rxbyterealign, rxbyteisaligned, rx_cdr_stable, rx_done, tx_done, qpll0lock, gtpowergood};
      sync_q <= meta_q;
      realign_prev_q <= realign_s;
    end
  end
  // next state: enable drop, then PLL/power loss, then per-state progress with success beating timeout
  always_comb begin
    stab_d = (aligned_s && !realign_ev) ? stab_q + SW'(1) : '0;
    state_d = state_q;
    if (state_q != IDLE && !enable) state_d = IDLE;
    else if (state_q inside {WAIT_TX, WAIT_RX, ALIGN, READY, RX_RST} && (!pg_s || !pll_s)) state_d = retry_tgt;
    else
      case (state_q)
        IDLE:     state_d = (enable && pg_s) ? RST_ALL : IDLE;
        RST_ALL:  state_d = pulse_done ? WAIT_PLL : RST_ALL;
        WAIT_PLL: state_d = pll_s ? WAIT_TX : timeout ? retry_tgt : WAIT_PLL;
        WAIT_TX:  state_d = tx_s ? WAIT_RX : timeout ? retry_tgt : WAIT_TX;
        WAIT_RX:  state_d = (rx_s && cdr_s) ? ALIGN : timeout ? rxrst_tgt : WAIT_RX;
        ALIGN:    state_d = (stab_d == SW'(ALIGN_STABLE_CYCLES)) ? READY : timeout ? rxrst_tgt : ALIGN;
        READY:    state_d = (!aligned_s || realign_ev) ? rxrst_tgt : READY;
        RX_RST:   state_d = pulse_done ? WAIT_RX : RX_RST;
        RETRY:    state_d = RST_ALL;
        default:  state_d = state_q;
      endcase
    retry_d = (state_d != state_q && state_d inside {RX_RST, RETRY} && retry_q != 8'hFF) ? retry_q + 8'd1 : retry_q;
    if (LIMIT_EN && state_q == FAILED && state_d == IDLE) retry_d = '0;
  end
  // state, counters and outputs registered from the next state so they line up with it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      stab_q <= '0;
      retry_q <= '0;
      reset_all_q <= 1'b1;
      reset_rx_q <= 1'b0;
      comma_q <= 1'b0;
      tx_ready_q <= 1'b0;
      rx_ready_q <= 1'b0;
      failed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= (state_d != state_q) ? '0 : (&cnt_q ? cnt_q : cnt_q + TW'(1));
      stab_q <= (state_q == ALIGN && state_d == ALIGN) ? stab_d : '0;
      retry_q <= retry_d;
      reset_all_q <= state_d inside {IDLE, RST_ALL, FAILED};
      reset_rx_q <= state_d == RX_RST;
      comma_q <= state_d inside {ALIGN, READY};
      tx_ready_q <= state_d inside {WAIT_RX, ALIGN, READY, RX_RST};
      rx_ready_q <= state_d == READY;
      failed_q <= LIMIT_EN && state_d == FAILED;
    end
  end
endmodule

// File: tb/tb_qeciphy_gt_link_sequencer.sv
// tb_qeciphy_gt_link_sequencer: randomized bench with a cycle-level reference model of the link sequencer
module tb_qeciphy_gt_link_sequencer;
  localparam int RP = 4, TO = 64, AS = 8, MR = 2;
  logic clk = 0, rst = 0, enable = 0, gtpowergood = 0, qpll0lock = 0, tx_done = 0;
  logic rx_done = 0, rx_cdr_stable = 0, rxbyteisaligned = 0, rxbyterealign = 0;
  logic reset_all, reset_rx_datapath, comma_align_en, tx_ready, rx_ready, failed;
  logic [3:0] state;
  logic [7:0] retry_count;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;

  qeciphy_gt_link_sequencer #(.RESET_PULSE_CYCLES(RP), .TIMEOUT_CYCLES(TO),
    .ALIGN_STABLE_CYCLES(AS), .MAX_RETRIES(MR)) dut (
    .clk(clk), .rst(rst), .enable(enable), .gtpowergood(gtpowergood), .qpll0lock(qpll0lock),
    .tx_done(tx_done), .rx_done(rx_done), .rx_cdr_stable(rx_cdr_stable),
    .rxbyteisaligned(rxbyteisaligned), .rxbyterealign(rxbyterealign),
    .reset_all(reset_all), .reset_rx_datapath(reset_rx_datapath), .comma_align_en(comma_align_en),
    .tx_ready(tx_ready), .rx_ready(rx_ready), .state(state), .retry_count(retry_count), .failed(failed));

  int m_st = 0, m_spent = 0, m_run = 0, m_rc = 0, m_nx = 0, m_runn = 0;
  logic [6:0] d1 = 0, d2 = 0, d3 = 0;
  bit m_pg, m_pl, m_tx, m_rx, m_cdr, m_al, m_ev, m_lim, m_rec;

  // reference: inputs seen two edges late, dwell time in cycles, aligned run length
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_st = 0; m_spent = 0; m_run = 0; m_rc = 0; d1 = 0; d2 = 0; d3 = 0;
    end else begin
      {m_pg, m_pl, m_tx, m_rx, m_cdr, m_al} = {d2[0], d2[1], d2[2], d2[3], d2[4], d2[5]};
      m_ev = d2[6] && !d3[6];
      m_spent++;
      m_runn = (m_al && !m_ev) ? m_run + 1 : 0;
`ifdef QECIPHY_GT_RETRY_LIMIT_EN
      m_lim = m_rc >= MR;
`else
      m_lim = 0;
`endif
      m_rec = 0;
      m_nx = m_st;
      if (m_st != 0 && !enable) m_nx = 0;
      else if (m_st >= 3 && m_st <= 7 && !(m_pg && m_pl)) m_rec = 1;
      else if (m_st == 0) m_nx = (enable && m_pg) ? 1 : 0;
      else if (m_st == 1) m_nx = (m_spent == RP) ? 2 : 1;
      else if (m_st == 2) begin if (m_pl) m_nx = 3; else if (m_spent >= TO) m_rec = 1; end
      else if (m_st == 3) begin if (m_tx) m_nx = 4; else if (m_spent >= TO) m_rec = 1; end
      else if (m_st == 4) begin if (m_rx && m_cdr) m_nx = 5; else if (m_spent >= TO) m_nx = 7; end
      else if (m_st == 5) begin if (m_runn >= AS) m_nx = 6; else if (m_spent >= TO) m_nx = 7; end
      else if (m_st == 6) begin if (!m_al || m_ev) m_nx = 7; end
      else if (m_st == 7) m_nx = (m_spent == RP) ? 4 : 7;
      else if (m_st == 8) m_nx = 1;
      if (m_rec) m_nx = 8;
      if (m_nx != m_st && (m_nx == 7 || m_nx == 8)) begin
        if (m_lim) m_nx = 9;
        else if (m_rc < 255) m_rc++;
      end
      if (m_st == 9 && m_nx == 0) m_rc = 0;
      m_run = (m_st == 5 && m_nx == 5) ? m_runn : 0;
      if (m_nx != m_st) m_spent = 0;
      m_st = m_nx;
      d3 = d2; d2 = d1;
      d1 = {rxbyterealign, rxbyteisaligned, rx_cdr_stable, rx_done, tx_done, qpll0lock, gtpowergood};
    end
  end

  function automatic logic [5:0] flags_of(input int s);
    return {s == 0 || s == 1 || s == 9, s == 7, s == 5 || s == 6, s >= 4 && s <= 7, s == 6, s == 9};
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      n_cmp++;
      if (state !== 4'(m_st) || retry_count !== 8'(m_rc) ||
          {reset_all, reset_rx_datapath, comma_align_en, tx_ready, rx_ready, failed} !== flags_of(m_st)) begin
        n_bad++;
        $display("FAIL model_cycle t=%0t: got st=%0d rc=%0d flags=%b want st=%0d rc=%0d flags=%b", $time,
          state, retry_count, {reset_all, reset_rx_datapath, comma_align_en, tx_ready, rx_ready, failed},
          m_st, m_rc, flags_of(m_st));
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic wait_st(input int s, input int lim, input string nm, output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (int'(state) != s && n < lim);
    if (int'(state) != s) chk({nm, "_timeout"}, int'(state), s);
  endtask

  task automatic count_in(input int s, output int n);
    n = 0;
    while (int'(state) == s && n < 1000) begin n++; @(negedge clk); end
  endtask

  task automatic inputs_low();
    {enable, gtpowergood, qpll0lock, tx_done, rx_done, rx_cdr_stable, rxbyteisaligned, rxbyterealign} = '0;
  endtask

  task automatic hard_reset();
    @(negedge clk); #2 rst = 1; inputs_low();
    @(negedge clk); #2 rst = 0;
  endtask

  task automatic bring_up(input bit lit);
    int n;
    @(negedge clk); enable = 1; gtpowergood = 1;
    wait_st(1, 8, "enter_rst_all", n);
    count_in(1, n);
    if (lit) chk("reset_all_cycles", n, RP);
    repeat ($urandom_range(0, 8)) @(negedge clk);
    qpll0lock = 1;
    wait_st(3, TO, "enter_wait_tx", n);
    repeat ($urandom_range(0, 8)) @(negedge clk);
    tx_done = 1;
    wait_st(4, 10, "enter_wait_rx", n);
    if (lit) chk("tx_ready_latency", n, 3);
    repeat ($urandom_range(0, 8)) @(negedge clk);
    rx_done = 1; rx_cdr_stable = 1;
    wait_st(5, 10, "enter_align", n);
    repeat ($urandom_range(0, 8)) @(negedge clk);
    rxbyteisaligned = 1;
    wait_st(6, 40, "enter_ready", n);
    if (lit) chk("rx_ready_latency", n, 10);
  endtask

  initial begin
    int n;
    #1 rst = 1;
    repeat (3) @(negedge clk);
    chk("rst_state", state, 0); chk("rst_reset_all", reset_all, 1);
    chk("rst_reset_rx", reset_rx_datapath, 0); chk("rst_comma", comma_align_en, 0);
    chk("rst_tx_ready", tx_ready, 0); chk("rst_rx_ready", rx_ready, 0);
    chk("rst_retry", retry_count, 0); chk("rst_failed", failed, 0);
    #2 rst = 0;
    bring_up(1);
    chk("nominal_retry", retry_count, 0);
    @(negedge clk); rxbyterealign = 1;
    @(negedge clk); rxbyterealign = 0;
    wait_st(7, 10, "realign_rx_rst", n);
    chk("realign_tx_ready", tx_ready, 1);
    chk("realign_rx_ready", rx_ready, 0);
    chk("realign_retry", retry_count, 1);
    count_in(7, n);
    chk("rx_rst_cycles", n, RP);
    wait_st(6, 30, "realign_ready_again", n);
    chk("realign_ready_again", rx_ready, 1);
    @(negedge clk); rxbyteisaligned = 0;
    wait_st(7, 10, "drop_rx_rst", n);
    wait_st(5, 20, "glitch_align", n);
    @(negedge clk); rxbyteisaligned = 1;
    repeat (5) @(negedge clk);
    rxbyteisaligned = 0;
    @(negedge clk); rxbyteisaligned = 1;
    wait_st(6, 30, "glitch_ready", n);
    chk("glitch_ready_latency", n, 10);
    chk("glitch_retry", retry_count, 2);
    @(negedge clk); #2 rst = 1;
    #1 chk("async_rst_state", state, 0); chk("async_rst_reset_all", reset_all, 1);
    chk("async_rst_tx_ready", tx_ready, 0); chk("async_rst_retry", retry_count, 0);
    inputs_low();
    @(negedge clk); #2 rst = 0;
    bring_up(0);
    @(negedge clk); qpll0lock = 0;
    wait_st(8, 3, "lock_loss_retry", n);
    chk("lock_loss_tx_ready", tx_ready, 0);
    chk("lock_loss_rx_ready", rx_ready, 0);
    chk("lock_loss_retry_count", retry_count, 1);
    qpll0lock = 1;
    wait_st(6, 200, "lock_loss_ready_again", n);
    chk("lock_loss_ready_again", rx_ready, 1);
    hard_reset();
    @(negedge clk); enable = 1; gtpowergood = 1;
    wait_st(2, 20, "pll_wait", n);
    count_in(2, n);
    chk("pll_timeout_cycles", n, TO);
    chk("pll_timeout_state", state, 8);
    chk("pll_timeout_retry", retry_count, 1);
    wait_st(1, 3, "pll_retry_rst_all", n);
    count_in(1, n);
    chk("retry_reset_all_cycles", n, RP);
`ifdef QECIPHY_GT_RETRY_LIMIT_EN
    wait_st(9, 400, "enter_failed", n);
    chk("failed_flag", failed, 1);
    chk("failed_reset_all", reset_all, 1);
    chk("failed_retry", retry_count, MR);
    @(negedge clk); enable = 0;
    wait_st(0, 4, "failed_to_idle", n);
    chk("failed_idle_retry", retry_count, 0);
`else
    n = 0;
    while (retry_count != 8'd255 && n < 20000) begin @(negedge clk); n++; end
    chk("retry_saturate", retry_count, 255);
    repeat (200) @(negedge clk);
    chk("retry_hold_255", retry_count, 255);
    chk("never_failed", failed, 0);
`endif
    hard_reset();
    @(negedge clk);
    {enable, gtpowergood, qpll0lock, tx_done, rx_done, rx_cdr_stable, rxbyteisaligned} = '1;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 299) == 0) enable = ~enable;
      if ($urandom_range(0, 60) == 0) gtpowergood = $urandom_range(0, 9) != 0;
      if ($urandom_range(0, 60) == 0) qpll0lock = $urandom_range(0, 9) != 0;
      if ($urandom_range(0, 40) == 0) tx_done = $urandom_range(0, 9) != 0;
      if ($urandom_range(0, 40) == 0) rx_done = $urandom_range(0, 9) != 0;
      if ($urandom_range(0, 40) == 0) rx_cdr_stable = $urandom_range(0, 9) != 0;
      if ($urandom_range(0, 30) == 0) rxbyteisaligned = $urandom_range(0, 5) != 0;
      rxbyterealign = $urandom_range(0, 120) == 0;
    end
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/qeciphy_gt_link_sequencer.md
Name: qeciphy_gt_link_sequencer

Overview:
- Bring-up and recovery controller for the GTH transceiver wrapper; runs on the transceiver free-running clock.
- Sequences the transceiver through: full reset, QPLL lock, TX and RX reset-done, comma alignment, then link ready.
- On loss of alignment, resets only the RX datapath. On loss of QPLL lock or power-good, repeats the full reset.
- Status outputs feed the PHY top-level and CSR block.

Parameters:
- RESET_PULSE_CYCLES, 16: cycles reset_all / reset_rx_datapath are held high per pulse (>=2).
- TIMEOUT_CYCLES, 1048576: max cycles in any WAIT_* or ALIGN state before recovery.
- ALIGN_STABLE_CYCLES, 256: consecutive aligned cycles required to declare rx_ready.
- MAX_RETRIES, 8: retry limit; used only with the optional feature.

Ports:
- clk  in  1  free-running clock, same clock as the transceiver reset-helper input
- rst  in  1  asynchronous, active-high reset
- enable  in  1  synchronous to clk; 1 = bring link up, 0 = hold transceiver in reset
- gtpowergood  in  1  async; GT power good
- qpll0lock  in  1  async; QPLL0 locked
- tx_done  in  1  async; TX reset done
- rx_done  in  1  async; RX reset done
- rx_cdr_stable  in  1  async; RX CDR stable
- rxbyteisaligned  in  1  async; byte aligned (level)
- rxbyterealign  in  1  async; realign event (pulse, >=1 rxusrclk2 cycle)
- reset_all  out  1  to the transceiver full reset input
- reset_rx_datapath  out  1  to the transceiver RX datapath reset input
- comma_align_en  out  1  drives comma detect enable and both comma-align enables
- tx_ready  out  1  TX path usable
- rx_ready  out  1  RX aligned and stable
- state  out  4  current state encoding
- retry_count  out  8  saturating count of recovery actions since rst
- failed  out  1  retry limit exhausted (constant 0 without the optional feature)

Behaviour:
- Synchronisation:
  - All async inputs pass through 2-flop synchronisers (suffix _s below); 2-cycle input latency.
  - rxbyterealign additionally passes through a rising-edge detector, giving a 1-cycle event.
- Reset values: state=IDLE, reset_all=1, reset_rx_datapath=0, comma_align_en=0, tx_ready=0, rx_ready=0, retry_count=0, failed=0. All counters 0. All outputs are registered.
- State encodings: IDLE=0, RST_ALL=1, WAIT_PLL=2, WAIT_TX=3, WAIT_RX=4, ALIGN=5, READY=6, RX_RST=7, RETRY=8, FAILED=9.
- Timeout counter: cleared on every state entry; width clog2(TIMEOUT_CYCLES+1).
- IDLE: reset_all=1. enable && gtpowergood_s -> RST_ALL.
- RST_ALL: reset_all=1 for exactly RESET_PULSE_CYCLES cycles, then reset_all=0 -> WAIT_PLL.
- WAIT_PLL: qpll0lock_s -> WAIT_TX. Timeout -> RETRY.
- WAIT_TX: tx_done_s -> WAIT_RX. Timeout -> RETRY.
- tx_ready: 1 in WAIT_RX, ALIGN, READY and RX_RST; 0 elsewhere.
- WAIT_RX: rx_done_s && rx_cdr_stable_s -> ALIGN. Timeout -> RX_RST.
- ALIGN:
  - comma_align_en=1.
  - Stable counter increments while rxbyteisaligned_s=1 with no realign event; clears otherwise.
  - Reaching ALIGN_STABLE_CYCLES -> READY. Timeout -> RX_RST.
- READY: comma_align_en=1, rx_ready=1. rxbyteisaligned_s=0 or realign event -> RX_RST.
- RX_RST:
  - reset_rx_datapath=1 for RESET_PULSE_CYCLES cycles; rx_ready=0; comma_align_en=0.
  - retry_count +1 on entry; then -> WAIT_RX.
- RETRY: 1 cycle; retry_count +1; -> RST_ALL.
- retry_count saturates at 255; no wrap.
- Global priority, evaluated every cycle in states other than IDLE:
  1. enable=0 -> IDLE; outputs to their reset values except retry_count, which holds.
  2. gtpowergood_s=0 or qpll0lock_s=0 in WAIT_TX..RX_RST -> RETRY.
  3. Local transitions above.
- Simultaneous events:
  - Realign event and stable count reaching the threshold in the same cycle: realign wins, counter clears, no READY.
  - Timeout in the same cycle as the success condition: success wins.
- rst asserted mid-operation: immediate return to reset values.

Optional Feature:
- Macro: QECIPHY_GT_RETRY_LIMIT_EN.
- Defined:
  - Entering RX_RST or RETRY when retry_count >= MAX_RETRIES goes to FAILED instead.
  - FAILED: reset_all=1, failed=1, all ready outputs 0.
  - Exits only on rst or enable=0; enable=0 -> IDLE and clears retry_count.
- Undefined: retries are unlimited, FAILED is unreachable, and failed is tied to 0.

Test Plan:
- Bench parameters: RESET_PULSE_CYCLES=4, TIMEOUT_CYCLES=64, ALIGN_STABLE_CYCLES=8, MAX_RETRIES=2.
- Nominal bring-up: enable=1, powergood=1, then lock/tx_done/rx_done/cdr/aligned in sequence -> reset_all high exactly 4 cycles; tx_ready after tx_done+2; rx_ready 8 cycles after aligned_s; retry_count=0.
- PLL timeout: qpll0lock held 0 -> RETRY after 64 cycles in WAIT_PLL, retry_count=1, new 4-cycle reset_all pulse.
- Realign in READY: 1-cycle rxbyterealign pulse -> rx_ready drops, reset_rx_datapath 4 cycles, tx_ready stays 1, retry_count +1, READY regained.
- Alignment glitch in ALIGN: aligned drops at stable count 5 -> counter restarts; READY only after 8 uninterrupted cycles.
- Lock loss in READY: qpll0lock=0 -> RETRY, tx_ready=0 and rx_ready=0 within 3 cycles, full sequence repeats.
- With QECIPHY_GT_RETRY_LIMIT_EN defined and a permanent PLL failure: third recovery -> FAILED, failed=1, reset_all=1; enable=0 -> IDLE and retry_count=0. Without the macro: no FAILED; retry_count saturates at 255.
